metronome_measure: RTL

METRONOME_MEASURE -- requirements
Module: metronome_measure

---
 rtl/metronome_measure.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/metronome_measure.sv
`timescale 1ns/1ps
// Programmable metronome: a tick every P cycles, grouped into subdivisions, beats and bars.
// Beat and bar lengths are latched at the start of each bar.
module metronome_measure #(
    parameter int CNT_W  = 34,
    parameter int BEAT_W = 4,
    parameter int SUB_W  = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [CNT_W-1:0]  i_period,
    input  logic              i_period_valid,
    input  logic [BEAT_W-1:0] i_beats_per_bar,
    input  logic [SUB_W-1:0]  i_subdiv,
    output logic              o_tick,
    output logic              o_beat,
    output logic              o_accent,
    output logic [BEAT_W-1:0] o_beat_idx,
    output logic [SUB_W-1:0]  o_sub_idx,
    output logic              o_running
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] PERIOD_MIN = CNT_W'(2);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [SUB_W-1:0]  sub_len_q, sub_len_d;
    logic [BEAT_W-1:0] beat_len_q, beat_len_d;
    logic [SUB_W-1:0]  sub_idx_q, sub_idx_d;
    logic [BEAT_W-1:0] beat_idx_q, beat_idx_d;
    logic              tick_q, tick_d;
    logic              beat_q, beat_d;
    logic              accent_q, accent_d;
    logic              running_q, running_d;

    logic [CNT_W-1:0]  period_eff;
    logic [CNT_W-1:0]  last_cnt;
    logic [SUB_W-1:0]  sub_len_in;
    logic [BEAT_W-1:0] beat_len_in;

    assign period_eff  = (period_q < PERIOD_MIN) ? PERIOD_MIN : period_q;
    assign last_cnt    = period_eff - CNT_W'(1);
    assign sub_len_in  = (i_subdiv == '0) ? SUB_W'(1) : i_subdiv;
    assign beat_len_in = (i_beats_per_bar == '0) ? BEAT_W'(1) : i_beats_per_bar;

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (i_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            period_q   <= PERIOD_MIN;
            sub_len_q  <= SUB_W'(1);
            beat_len_q <= BEAT_W'(1);
            sub_idx_q  <= '0;
            beat_idx_q <= '0;
            tick_q     <= 1'b0;
            beat_q     <= 1'b0;
            accent_q   <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            sub_len_q  <= sub_len_d;
            beat_len_q <= beat_len_d;
            sub_idx_q  <= sub_idx_d;
            beat_idx_q <= beat_idx_d;
            tick_q     <= tick_d;
            beat_q     <= beat_d;
            accent_q   <= accent_d;
            running_q  <= running_d;
        end
    end

    always_comb begin
        // NOTE: every _d gets a default first so no latch can be inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = i_period_valid ? i_period : period_q;
        sub_len_d  = sub_len_q;
        beat_len_d = beat_len_q;
        sub_idx_d  = sub_idx_q;
        beat_idx_d = beat_idx_q;
        tick_d     = 1'b0;
        beat_d     = 1'b0;
        accent_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_enable) begin
                    state_d    = RUN;
                    cnt_d      = '0;
                    sub_idx_d  = '0;
                    beat_idx_d = '0;
                    tick_d     = 1'b1;
                    beat_d     = 1'b1;
                    accent_d   = 1'b1;
                    sub_len_d  = sub_len_in;
                    beat_len_d = beat_len_in;
                end
            end
            RUN: begin
                if (!i_enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (i_period_valid) begin
                    // A reload restarts the tick interval and beats a coincident tick.
                    cnt_d = '0;
                end else if (cnt_q >= last_cnt) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    if (sub_idx_q >= sub_len_q - SUB_W'(1)) begin
                        sub_idx_d = '0;
                        beat_d    = 1'b1;
                        if (beat_idx_q >= beat_len_q - BEAT_W'(1)) begin
                            beat_idx_d = '0;
                            accent_d   = 1'b1;
                            sub_len_d  = sub_len_in;
                            beat_len_d = beat_len_in;
                        end else begin
                            beat_idx_d = beat_idx_q + BEAT_W'(1);
                        end
                    end else begin
                        sub_idx_d = sub_idx_q + SUB_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        running_d = (state_d == RUN);
    end

    assign o_tick     = tick_q;
    assign o_beat     = beat_q;
    assign o_accent   = accent_q;
    assign o_beat_idx = beat_idx_q;
    assign o_sub_idx  = sub_idx_q;
    assign o_running  = running_q;

endmodule
